// File: rtl/booth_r4_sequencer_pkg.sv
// Shared types for the radix-4 Booth sequencer: FSM states, Booth select codes, default operand width.
// No logic; imported by the encoder and the sequencer top.
package booth_r4_sequencer_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_P1   = 3'd1,
    SEL_P2   = 3'd2,
    SEL_N2   = 3'd3,
    SEL_N1   = 3'd4
  } booth_sel_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder: one multiplier triplet plus multiplicand -> partial product.
// Purely combinational; negative digits leave the +1 of the two's complement to the adder carry-in.
module booth_r4_encoder
  import booth_r4_sequencer_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int MD_W = N + 3
) (
  input  logic [2:0]      triplet,
  input  logic [N-1:0]    m,
  output logic [MD_W-1:0] md,
  output logic            cla_sub
);

  booth_sel_t      sel;
  logic [MD_W-1:0] m_ext;
  logic [MD_W-1:0] m_x2;

  assign m_ext = {{(MD_W - N){m[N-1]}}, m};
  assign m_x2  = {m_ext[MD_W-2:0], 1'b0};

  always_comb begin
    sel = SEL_ZERO;
    case (triplet)
      3'b001, 3'b010: sel = SEL_P1;
      3'b011:         sel = SEL_P2;
      3'b100:         sel = SEL_N2;
      3'b101, 3'b110: sel = SEL_N1;
      default:        sel = SEL_ZERO;
    endcase
  end

  always_comb begin
    md      = '0;
    cla_sub = 1'b0;
    case (sel)
      SEL_P1: md = m_ext;
      SEL_P2: md = m_x2;
      SEL_N2: begin
        md      = ~m_x2;
        cla_sub = 1'b1;
      end
      SEL_N1: begin
        md      = ~m_ext;
        cla_sub = 1'b1;
      end
      default: md = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_sequencer.sv
// Sequencer for the shift-add multiplier: load pulse, N/2 Booth partial products, done pulse.
// start -> done takes N/2+2 cycles; start is only honoured in IDLE, all outputs are registered.
module booth_r4_sequencer
  import booth_r4_sequencer_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int MD_W = N + 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    mcand,
  input  logic [N-1:0]    mplier,
  output logic            busy,
  output logic            load,
  output logic [MD_W-1:0] md,
  output logic            cla_sub,
  output logic            done
);

  localparam int               CNT_W = $clog2(N / 2);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N / 2 - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]    m_q;
  logic [N:0]      q_q;
  logic [2:0]      trip;
  logic [MD_W-1:0] enc_md;
  logic            enc_sub;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so encode the triplet that will be current next cycle:
  // LOAD->RUN keeps Q as is, RUN->RUN sees Q after the 2-bit shift.
  assign trip = (state == LOAD) ? q_q[2:0] : q_q[4:2];

  booth_r4_encoder #(
    .N    (N),
    .MD_W (MD_W)
  ) u_enc (
    .triplet (trip),
    .m       (m_q),
    .md      (enc_md),
    .cla_sub (enc_sub)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      busy    <= 1'b0;
      load    <= 1'b0;
      md      <= '0;
      cla_sub <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == LOAD) || (state_nxt == RUN);
      load  <= (state_nxt == LOAD);
      done  <= (state_nxt == DONE);
      if (state_nxt == RUN) begin
        md      <= enc_md;
        cla_sub <= enc_sub;
      end else begin
        md      <= '0;
        cla_sub <= 1'b0;
      end

      if (state == IDLE && start) begin
        m_q <= mcand;
        q_q <= {mplier, 1'b0};
        cnt <= '0;
      end else if (state == RUN) begin
        q_q <= {{2{q_q[N]}}, q_q[N:2]};
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_sequencer.sv
// Bench for booth_r4_sequencer (N=8): directed and random multiplies scored against Booth-digit arithmetic
// and a modelled downstream accumulator.
module tb_booth_r4_sequencer;

  localparam int N    = 8;
  localparam int MD_W = 11;

  logic            clk;
  logic            rst;
  logic            start;
  logic [N-1:0]    mcand;
  logic [N-1:0]    mplier;
  logic            busy;
  logic            load;
  logic [MD_W-1:0] md;
  logic            cla_sub;
  logic            done;

  int n_vec;
  int n_err;

  booth_r4_sequencer #(.N(N), .MD_W(MD_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .load    (load),
    .md      (md),
    .cla_sub (cla_sub),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Booth digit k of multiplier b, straight from its definition: -2*b[2k+1] + b[2k] + b[2k-1].
  function automatic int digit(input logic [N-1:0] b, input int k);
    int hi, mid, lo;
    hi  = int'(b[2*k+1]);
    mid = int'(b[2*k]);
    lo  = (k == 0) ? 0 : int'(b[2*k-1]);
    return -2 * hi + mid + lo;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_load"}, 32'(load), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_md"},   32'(md),   32'd0);
    chk({tag, "_cla"},  32'(cla_sub), 32'd0);
  endtask

  // One full multiply. pre_launched: start/operands already driven during the previous DONE cycle,
  // so an IDLE cycle is expected first. noisy: scramble start/operands while the op is in flight.
  // chain: leave start high with next operands at the DONE cycle.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit pre_launched,
                       input bit noisy, input bit chain, input logic [N-1:0] na, input logic [N-1:0] nb);
    int sa, prod, acc, d, exp_md, mdv;
    sa = int'($signed(a));
    prod = sa * int'($signed(b));
    acc = 0;
    if (pre_launched) begin
      step();
      chk("idle_gap_load", 32'(load), 32'd0);
      chk("idle_gap_busy", 32'(busy), 32'd0);
    end else begin
      mcand = a; mplier = b; start = 1'b1;
    end
    step();
    chk("load_pulse", 32'(load), 32'd1);
    chk("load_busy",  32'(busy), 32'd1);
    chk("load_md",    32'(md),   32'd0);
    if (noisy) begin
      start = 1'b1; mcand = N'($urandom); mplier = N'($urandom);
    end else begin
      start = 1'b0;
    end
    for (int k = 0; k < N / 2; k++) begin
      step();
      d = digit(b, k);
      exp_md = (d < 0) ? d * sa - 1 : d * sa;
      chk("run_md",   32'(md), 32'(exp_md[MD_W-1:0]));
      chk("run_cla",  32'(cla_sub), (d < 0) ? 32'd1 : 32'd0);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_load", 32'(load), 32'd0);
      mdv = int'($signed(md));
      acc = acc + (mdv + int'(cla_sub)) * (1 << (2 * k));
      if (noisy) begin
        mcand = N'($urandom); mplier = N'($urandom);
      end
    end
    step();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy",  32'(busy), 32'd0);
    chk("done_md",    32'(md),   32'd0);
    chk("product",    32'(acc[15:0]), 32'(prod[15:0]));
    if (chain) begin
      start = 1'b1; mcand = na; mplier = nb;
    end else begin
      start = 1'b0;
      step();
      chk("post_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] a, b, na, nb;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b1; mcand = 8'd3; mplier = 8'd5;
    step();
    chk_idle("rst1");
    mcand = N'($urandom); mplier = N'($urandom);
    step();
    chk_idle("rst2");
    rst = 1'b0; start = 1'b0;
    step();
    chk_idle("post_rst");

    do_op(8'd3,   8'd5,   1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    do_op(8'd127, 8'h80,  1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    do_op(8'h80,  8'd3,   1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    do_op(8'h80,  8'h80,  1'b0, 1'b0, 1'b1, 8'h7f, 8'h7f);
    do_op(8'h7f,  8'h7f,  1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

    // Abort during RUN k=2: no done, then a fresh op must still be right.
    mcand = 8'd77; mplier = 8'hb5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk_idle("abort");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_busy", 32'(busy), 32'd0);
    end
    do_op(8'hf3, 8'h2b, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    a = N'($urandom); b = N'($urandom);
    for (int i = 0; i < 30; i++) begin
      na = N'($urandom); nb = N'($urandom);
      do_op(a, b, (i % 3 == 1) || (i % 3 == 2) ? 1'b0 : 1'b0, i[0], 1'b0, na, nb);
      a = na; b = nb;
    end
    for (int i = 0; i < 10; i++) begin
      na = N'($urandom); nb = N'($urandom);
      do_op(a, b, (i != 0), 1'b1, (i != 9), na, nb);
      a = na; b = nb;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
